// File: rtl/fifo_cmd_reader.sv
// Read-side consumer of the 1-word clock-crossing command fifo.
// Fetches header/address/data words with the slow empty_n/rd handshake,
// issues one read or write to the SDRAM controller per command, and
// returns read data on a one-cycle response strobe.
`timescale 1ns/1ps
module fifo_cmd_reader #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_WIDTH-1:0]  fifo_data,
  input  logic                  fifo_empty_n,
  output logic                  fifo_rd,
  output logic [ADDR_WIDTH-1:0] ctl_addr,
  output logic [BUS_WIDTH-1:0]  ctl_wr_data,
  output logic                  ctl_wr_enable,
  output logic                  ctl_rd_enable,
  input  logic                  ctl_busy,
  input  logic [BUS_WIDTH-1:0]  ctl_rd_data,
  input  logic                  ctl_rd_ready,
  output logic [BUS_WIDTH-1:0]  rsp_data,
  output logic                  rsp_valid,
  output logic                  proto_err
);

  // Header layout: op in the MSB, upper address bits at the bottom,
  // everything in between is reserved and must read as zero.
  localparam int HI_W = ADDR_WIDTH - BUS_WIDTH;
  localparam logic [BUS_WIDTH-1:0] HI_MASK  = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - HI_W);
  localparam logic [BUS_WIDTH-1:0] RSV_MASK = ~HI_MASK & {1'b0, {(BUS_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_WAIT_RD
  } state_e;

  typedef enum logic {
    F_IDLE,
    F_RELEASE
  } fetch_e;

  state_e                  state_q,     state_d;
  fetch_e                  fetch_q,     fetch_d;
  logic                    fifo_rd_q,   fifo_rd_d;
  logic [BUS_WIDTH-1:0]    word_q,      word_d;
  logic                    op_q,        op_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [BUS_WIDTH-1:0]    wr_data_q,   wr_data_d;
  logic                    wr_en_q,     wr_en_d;
  logic                    rd_en_q,     rd_en_d;
  logic [BUS_WIDTH-1:0]    rsp_data_q,  rsp_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    proto_err_q, proto_err_d;

  logic                    fetch_active;
  logic                    released;

  // Next-state logic: word fetch handshake, command decode and issue.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    fetch_d      = fetch_q;
    fifo_rd_d    = fifo_rd_q;
    word_d       = word_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = wr_en_q;
    rd_en_d      = rd_en_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = 1'b0;
    proto_err_d  = 1'b0;
    released     = 1'b0;

    fetch_active = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_DATA);

    // Capture once on empty_n, then hold rd until the fifo withdraws the
    // word; capturing only in F_IDLE guarantees one capture per word.
    if (fetch_active) begin
      case (fetch_q)
        F_IDLE: begin
          if (fifo_empty_n) begin
            word_d    = fifo_data;
            fifo_rd_d = 1'b1;
            fetch_d   = F_RELEASE;
          end
        end
        F_RELEASE: begin
          if (!fifo_empty_n) begin
            fifo_rd_d = 1'b0;
            fetch_d   = F_IDLE;
            released  = 1'b1;
          end
        end
        default: fetch_d = F_IDLE;
      endcase
    end

    case (state_q)
      S_HDR: begin
        if (released) begin
          if ((word_q & RSV_MASK) != '0) begin
            proto_err_d = 1'b1;
          end else begin
            op_d                              = word_q[BUS_WIDTH-1];
            addr_d[ADDR_WIDTH-1:BUS_WIDTH]    = word_q[HI_W-1:0];
            state_d                           = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (released) begin
          addr_d[BUS_WIDTH-1:0] = word_q;
          state_d               = op_q ? S_DATA : S_ISSUE;
        end
      end
      S_DATA: begin
        if (released) begin
          wr_data_d = word_q;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Raise only while the controller is idle; drop once it reports busy.
        if (!wr_en_q && !rd_en_q) begin
          if (!ctl_busy) begin
            wr_en_d = op_q;
            rd_en_d = !op_q;
          end
        end else if (ctl_busy) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          state_d = op_q ? S_HDR : S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (ctl_rd_ready) begin
          rsp_data_d  = ctl_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      fetch_q     <= F_IDLE;
      fifo_rd_q   <= 1'b0;
      word_q      <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      fifo_rd_q   <= fifo_rd_d;
      word_q      <= word_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign fifo_rd       = fifo_rd_q;
  assign ctl_addr      = addr_q;
  assign ctl_wr_data   = wr_data_q;
  assign ctl_wr_enable = wr_en_q;
  assign ctl_rd_enable = rd_en_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Testbench for fifo_cmd_reader: directed scenarios plus a randomized
// command stream, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_fifo_cmd_reader;

  localparam int BW = 16;
  localparam int AW = 24;
  localparam int HW = AW - BW;
  localparam logic [BW-1:0] RSV = 16'h7F00;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] fifo_data;
  logic          fifo_empty_n;
  logic          fifo_rd;
  logic [AW-1:0] ctl_addr;
  logic [BW-1:0] ctl_wr_data;
  logic          ctl_wr_enable;
  logic          ctl_rd_enable;
  logic          ctl_busy;
  logic [BW-1:0] ctl_rd_data;
  logic          ctl_rd_ready;
  logic [BW-1:0] rsp_data;
  logic          rsp_valid;
  logic          proto_err;

  fifo_cmd_reader #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_data    (fifo_data),
    .fifo_empty_n (fifo_empty_n),
    .fifo_rd      (fifo_rd),
    .ctl_addr     (ctl_addr),
    .ctl_wr_data  (ctl_wr_data),
    .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_enable(ctl_rd_enable),
    .ctl_busy     (ctl_busy),
    .ctl_rd_data  (ctl_rd_data),
    .ctl_rd_ready (ctl_rd_ready),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- controller model ----------------
  bit            force_busy = 1'b0;
  bit            quiet      = 1'b1;
  logic          rnd_busy   = 1'b0;
  int            dir_delay  = 0;
  logic [BW-1:0] dir_data   = '0;
  bit            rd_seen    = 1'b0;
  int            rd_cnt     = 0;

  assign ctl_busy = force_busy | rnd_busy;

  initial begin
    ctl_rd_ready = 1'b0;
    ctl_rd_data  = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rnd_busy     = 1'b0;
      ctl_rd_ready = 1'b0;
      rd_seen      = 1'b0;
    end else begin
      if (ctl_wr_enable || ctl_rd_enable) rnd_busy = quiet ? 1'b1 : ($urandom_range(0, 2) == 0);
      else                                rnd_busy = quiet ? 1'b0 : ($urandom_range(0, 7) == 0);
      ctl_rd_ready = 1'b0;
      if (ctl_rd_enable && !rd_seen) begin
        rd_seen = 1'b1;
        rd_cnt  = (dir_delay != 0) ? dir_delay : int'($urandom_range(1, 12));
      end else if (rd_seen && !ctl_rd_enable) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          ctl_rd_ready = 1'b1;
          ctl_rd_data  = (dir_delay != 0) ? dir_data : 16'($urandom);
          rd_seen      = 1'b0;
        end
      end else if (!rd_seen && !ctl_rd_enable && !quiet && $urandom_range(0, 15) == 0) begin
        ctl_rd_ready = 1'b1;               // stray strobe, must be ignored
        ctl_rd_data  = 16'($urandom);
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  logic [BW-1:0] tb_words[$];   // words presented by the fifo, in order
  logic [BW-1:0] mw[$];         // words of the command being assembled
  bit            armed = 1'b0, hi = 1'b0, waiting = 1'b0;
  bit            exp_op;
  logic [AW-1:0] exp_addr;
  logic [BW-1:0] exp_data;
  logic          p_rd = 1'b0;
  bit            m_fetch_ok, m_release, m_exp_rd, m_exp_perr, m_exp_rsp;
  logic [BW-1:0] m_w;
  int            n_rsp = 0, n_perr = 0, n_rd_rise = 0, n_issue = 0, en_hi_cycles = 0;
  bit            last_op;
  logic [AW-1:0] last_addr;
  logic [BW-1:0] last_data, last_rsp;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      armed = 1'b0; hi = 1'b0; waiting = 1'b0;
      mw.delete();
    end else begin
      m_fetch_ok = !armed && !waiting;
      m_release  = p_rd && !fifo_empty_n;
      m_exp_rd   = p_rd ? fifo_empty_n : (m_fetch_ok && fifo_empty_n);
      check("fifo_rd", fifo_rd, m_exp_rd);
      if (fifo_rd && !p_rd) n_rd_rise++;

      m_exp_rsp = waiting && ctl_rd_ready;
      check("rsp_valid", rsp_valid, m_exp_rsp);
      if (m_exp_rsp) begin
        check("rsp_data", rsp_data, ctl_rd_data);
        waiting = 1'b0;
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp = rsp_data;
      end

      if (!armed) begin
        check("wr_en_idle", ctl_wr_enable, 0);
        check("rd_en_idle", ctl_rd_enable, 0);
      end else if (!hi) begin
        if (!ctl_busy) begin
          check("wr_en_rise", ctl_wr_enable, exp_op);
          check("rd_en_rise", ctl_rd_enable, !exp_op);
          check("issue_addr", ctl_addr, exp_addr);
          if (exp_op) check("issue_wr_data", ctl_wr_data, exp_data);
          hi = 1'b1;
          n_issue++;
          last_op = ctl_wr_enable; last_addr = ctl_addr; last_data = ctl_wr_data;
        end else begin
          check("wr_en_busy", ctl_wr_enable, 0);
          check("rd_en_busy", ctl_rd_enable, 0);
        end
      end else begin
        if (ctl_busy) begin
          check("wr_en_drop", ctl_wr_enable, 0);
          check("rd_en_drop", ctl_rd_enable, 0);
          armed = 1'b0; hi = 1'b0; waiting = !exp_op;
        end else begin
          check("wr_en_hold", ctl_wr_enable, exp_op);
          check("rd_en_hold", ctl_rd_enable, !exp_op);
          check("addr_stable", ctl_addr, exp_addr);
        end
      end
      if (ctl_wr_enable || ctl_rd_enable) en_hi_cycles++;

      m_exp_perr = 1'b0;
      if (m_release) begin
        if (tb_words.size() == 0) begin
          check("word_available", 0, 1);
        end else begin
          m_w = tb_words.pop_front();
          mw.push_back(m_w);
          if (mw.size() == 1 && (mw[0] & RSV) != '0) begin
            m_exp_perr = 1'b1;
            mw.delete();
          end else if (mw.size() == (mw[0][BW-1] ? 3 : 2)) begin
            exp_op   = mw[0][BW-1];
            exp_addr = {mw[0][HW-1:0], mw[1]};
            if (exp_op) exp_data = mw[2];
            armed = 1'b1;
            mw.delete();
          end
        end
      end
      check("proto_err", proto_err, m_exp_perr);
      if (proto_err) n_perr++;
    end
    p_rd = fifo_rd;
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [BW-1:0] w, input int hold);
    int t;
    @(negedge clk);
    fifo_data    = w;
    fifo_empty_n = 1'b1;
    tb_words.push_back(w);
    t = 0;
    while ((t < hold || !fifo_rd) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("fifo_rd_wait", fifo_rd, 1);
    fifo_empty_n = 1'b0;
    t = 0;
    while (fifo_rd && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("fifo_rd_release", fifo_rd, 0);
  endtask

  task automatic send_cmd(input bit op, input logic [AW-1:0] a, input logic [BW-1:0] d, input int hold);
    send_word({op, {(BW-1-HW){1'b0}}, a[AW-1:BW]}, hold);
    send_word(a[BW-1:0], hold);
    if (op) send_word(d, hold);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((armed || waiting) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", armed || waiting, 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {fifo_rd, ctl_wr_enable, ctl_rd_enable, rsp_valid, proto_err,
                 |ctl_addr, |ctl_wr_data, |rsp_data}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  int snap, snap2;

  initial begin
    rst_n        = 1'b0;
    fifo_data    = '0;
    fifo_empty_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Write: 0x8012, 0x3456, 0xBEEF, each presented for 8 cycles
    snap = n_rsp; snap2 = n_rd_rise;
    send_word(16'h8012, 8);
    send_word(16'h3456, 8);
    send_word(16'hBEEF, 8);
    wait_idle();
    check("wr_op",   last_op, 1);
    check("wr_addr", last_addr, 24'h123456);
    check("wr_data", last_data, 16'hBEEF);
    check("wr_no_rsp", n_rsp - snap, 0);
    check("wr_rd_pulses", n_rd_rise - snap2, 3);

    // Read: 0x00AB, 0x0001, data 0xCAFE returned 20 cycles later
    dir_delay = 20; dir_data = 16'hCAFE;
    snap = n_rsp;
    send_word(16'h00AB, 4);
    send_word(16'h0001, 4);
    wait_idle();
    check("rd_op",   last_op, 0);
    check("rd_addr", last_addr, 24'hAB0001);
    check("rd_rsp_data", last_rsp, 16'hCAFE);
    check("rd_rsp_count", n_rsp - snap, 1);
    dir_delay = 0;

    // Controller busy for 30 cycles when the command reaches issue
    force_busy = 1'b1;
    send_cmd(1'b0, 24'h123400, 16'h0000, 2);
    snap = en_hi_cycles;
    repeat (30) @(negedge clk);
    check("busy_no_enable", en_hi_cycles - snap, 0);
    force_busy = 1'b0;
    @(posedge clk);
    #1;
    check("enable_after_busy", ctl_rd_enable, 1);
    wait_idle();
    check("busy_addr", last_addr, 24'h123400);

    // Malformed header followed by a valid read of 0x000004
    snap = n_perr; snap2 = n_issue;
    send_word(16'h0100, 4);
    send_word(16'h0000, 4);
    send_word(16'h0004, 4);
    wait_idle();
    check("perr_count", n_perr - snap, 1);
    check("perr_issue_count", n_issue - snap2, 1);
    check("perr_rd_addr", last_addr, 24'h000004);

    // One header held for 50 cycles is captured exactly once
    snap = n_rd_rise;
    send_word(16'h8001, 50);
    repeat (5) @(negedge clk);
    check("long_single_capture", n_rd_rise - snap, 1);
    check("long_no_enable", ctl_wr_enable | ctl_rd_enable, 0);
    send_word(16'h0002, 3);
    send_word(16'h1111, 3);
    wait_idle();
    check("long_addr", last_addr, 24'h010002);
    check("long_data", last_data, 16'h1111);

    // Reset while waiting for read data
    dir_delay = 60; dir_data = 16'h5555;
    send_cmd(1'b0, 24'h770ABC, 16'h0000, 2);
    snap = 0;
    while (!waiting && snap < 200) begin
      @(negedge clk);
      snap++;
    end
    check("reached_wait_rd", waiting, 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    dir_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(1'b1, 24'h050006, 16'h7777, 2);
    wait_idle();
    check("post_reset_addr", last_addr, 24'h050006);
    check("post_reset_data", last_data, 16'h7777);

    // Randomized command stream with random controller behaviour
    quiet = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_word(16'($urandom) | (16'h0100 << $urandom_range(0, 6)), int'($urandom_range(0, 5)));
      end else begin
        send_cmd(1'($urandom), 24'($urandom), 16'($urandom), int'($urandom_range(0, 6)));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    quiet = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
